// File: rtl/pool_cu_gen.sv
// Control unit for a KxK / stride-S pooling layer: raster reads of the current
// feature map, line-buffer and pool enables, and ping-pong writes to the next layer.
module pool_cu_gen #(
    parameter int IFM_SIZE              = 14,
    parameter int IFM_DEPTH             = 6,
    parameter int KERNAL_SIZE           = 2,
    parameter int STRIDE                = 2,
    parameter int POOL_LATENCY          = 3,
    parameter int IFM_SIZE_NEXT         = (IFM_SIZE - KERNAL_SIZE) / STRIDE + 1,
    parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
    parameter int ADDRESS_SIZE_NEXT_IFM = (IFM_SIZE_NEXT > 1) ? $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT) : 1,
    parameter int CH_W                  = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start_from_previous,
    input  logic                             end_from_next,
    input  logic                             pool_mode_in,
    output logic                             end_to_previous,
    output logic                             ifm_enable_read_current,
    output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_current,
    output logic [CH_W-1:0]                  ifm_channel_read_current,
    output logic                             fifo_enable,
    output logic                             pool_enable,
    output logic                             pool_mode,
    output logic                             ifm_enable_write_next,
    output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next,
    output logic [CH_W-1:0]                  ifm_channel_write_next,
    output logic                             start_to_next,
    output logic                             ifm_sel_next
);

    localparam int CW = (IFM_SIZE > 1) ? $clog2(IFM_SIZE) : 1;
    localparam int SW = (STRIDE > 1) ? $clog2(STRIDE) : 1;
    localparam logic [CW-1:0]                    LAST_POS = CW'(IFM_SIZE - 1);
    localparam logic [CW-1:0]                    K_M1     = CW'(KERNAL_SIZE - 1);
    localparam logic [SW-1:0]                    S_M1     = SW'(STRIDE - 1);
    localparam logic [CH_W-1:0]                  LAST_CH  = CH_W'(IFM_DEPTH - 1);
    localparam logic [ADDRESS_SIZE_NEXT_IFM-1:0] LAST_WR  = ADDRESS_SIZE_NEXT_IFM'(IFM_SIZE_NEXT * IFM_SIZE_NEXT - 1);

    typedef enum logic [1:0] {IDLE, READ, HOLD, FINISH} main_state_t;
    typedef enum logic {EMPTY, FULL} out_state_t;

    main_state_t state;
    out_state_t  out_state;

    logic [CW-1:0]               col, row, nxt_col, nxt_row;
    logic [SW-1:0]               col_st, row_st, nxt_col_st, nxt_row_st;
    logic [ADDRESS_SIZE_IFM-1:0] nxt_addr;
    logic [CH_W-1:0]             nxt_ch;
    logic                        last_col, last_row, frame_done, window, hold_point, bank_free;
    logic [POOL_LATENCY-1:0]     pe_dly;

    // Stride phase counters are pinned at 0 until the first full window, then count mod S.
    always_comb begin
        last_col   = (col == LAST_POS);
        last_row   = (row == LAST_POS);
        frame_done = last_col && last_row && (ifm_channel_read_current == LAST_CH);
        nxt_col    = last_col ? '0 : col + 1'b1;
        nxt_row    = last_col ? (last_row ? '0 : row + 1'b1) : row;
        nxt_ch     = ifm_channel_read_current;
        nxt_addr   = ifm_address_read_current + 1'b1;
        if (last_col && last_row) begin
            nxt_addr = '0;
            nxt_ch   = (ifm_channel_read_current == LAST_CH) ? '0 : ifm_channel_read_current + 1'b1;
        end
        nxt_col_st = (nxt_col <= K_M1) ? '0 : ((col_st == S_M1) ? '0 : col_st + 1'b1);
        nxt_row_st = row_st;
        if (last_col)
            nxt_row_st = (nxt_row <= K_M1) ? '0 : ((row_st == S_M1) ? '0 : row_st + 1'b1);
        window     = (row >= K_M1) && (col >= K_M1) && (row_st == '0) && (col_st == '0);
        hold_point = (out_state == FULL) && (nxt_row == K_M1) && (nxt_col == '0) && (nxt_ch == '0);
        bank_free  = (out_state == EMPTY) || start_to_next;
    end

    assign start_to_next         = (out_state == FULL) && end_from_next;
    assign ifm_enable_write_next = pe_dly[POOL_LATENCY-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                    <= IDLE;
            col                      <= '0;
            row                      <= '0;
            col_st                   <= '0;
            row_st                   <= '0;
            ifm_address_read_current <= '0;
            ifm_channel_read_current <= '0;
            ifm_enable_read_current  <= 1'b0;
            end_to_previous          <= 1'b1;
            fifo_enable              <= 1'b0;
            pool_enable              <= 1'b0;
            pool_mode                <= 1'b0;
        end else begin
            fifo_enable <= ifm_enable_read_current;
            pool_enable <= ifm_enable_read_current && window;
            case (state)
                IDLE, FINISH: begin
                    if (start_from_previous) begin
                        pool_mode       <= pool_mode_in;
                        end_to_previous <= 1'b0;
                        // With K=1 the first write lands on pixel 0, so a busy bank blocks immediately.
                        if (KERNAL_SIZE == 1 && out_state == FULL) begin
                            state <= HOLD;
                        end else begin
                            state                   <= READ;
                            ifm_enable_read_current <= 1'b1;
                        end
                    end
                end
                READ: begin
                    col                      <= nxt_col;
                    row                      <= nxt_row;
                    col_st                   <= nxt_col_st;
                    row_st                   <= nxt_row_st;
                    ifm_address_read_current <= nxt_addr;
                    ifm_channel_read_current <= nxt_ch;
                    if (frame_done) begin
                        state                   <= FINISH;
                        ifm_enable_read_current <= 1'b0;
                        end_to_previous         <= 1'b1;
                    end else if (hold_point) begin
                        state                   <= HOLD;
                        ifm_enable_read_current <= 1'b0;
                    end
                end
                HOLD: begin
                    if (bank_free) begin
                        state                   <= READ;
                        ifm_enable_read_current <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pe_dly                 <= '0;
            ifm_address_write_next <= '0;
            ifm_channel_write_next <= '0;
            out_state              <= EMPTY;
            ifm_sel_next           <= 1'b0;
        end else begin
            pe_dly <= (pe_dly << 1) | POOL_LATENCY'(pool_enable);
            if (ifm_enable_write_next) begin
                if (ifm_address_write_next == LAST_WR) begin
                    ifm_address_write_next <= '0;
                    if (ifm_channel_write_next == LAST_CH) begin
                        ifm_channel_write_next <= '0;
                        out_state              <= FULL;
                    end else begin
                        ifm_channel_write_next <= ifm_channel_write_next + 1'b1;
                    end
                end else begin
                    ifm_address_write_next <= ifm_address_write_next + 1'b1;
                end
            end
            if (start_to_next) begin
                out_state    <= EMPTY;
                ifm_sel_next <= ~ifm_sel_next;
            end
        end
    end

endmodule

// File: tb/tb_pool_cu_gen.sv
// Scoreboard bench: two pooling configurations, queues of expected reads,
// pool pixels, writes and bank handoffs checked by free-running monitors.
module tb_pool_cu_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    function automatic void chk(input string nm, input int act, input int exp_v);
        n_total++;
        if (act == exp_v) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    endfunction

    // DUT A: N=4 K=2 S=2 C=2
    logic reset_a, start_a, efn_a, pmi_a;
    logic etp_a, rd_a, fifo_a, pe_a, pm_a, wr_a, st_a, sel_a;
    logic [3:0] ra_a;
    logic [0:0] rc_a, wc_a;
    logic [1:0] wa_a;

    pool_cu_gen #(.IFM_SIZE(4), .IFM_DEPTH(2), .KERNAL_SIZE(2), .STRIDE(2), .POOL_LATENCY(3)) dut_a (
        .clk(clk), .reset(reset_a), .start_from_previous(start_a), .end_from_next(efn_a),
        .pool_mode_in(pmi_a), .end_to_previous(etp_a), .ifm_enable_read_current(rd_a),
        .ifm_address_read_current(ra_a), .ifm_channel_read_current(rc_a), .fifo_enable(fifo_a),
        .pool_enable(pe_a), .pool_mode(pm_a), .ifm_enable_write_next(wr_a),
        .ifm_address_write_next(wa_a), .ifm_channel_write_next(wc_a),
        .start_to_next(st_a), .ifm_sel_next(sel_a)
    );

    // DUT B: N=5 K=3 S=1 C=1
    logic reset_b, start_b, efn_b, pmi_b;
    logic etp_b, rd_b, fifo_b, pe_b, pm_b, wr_b, st_b, sel_b;
    logic [4:0] ra_b;
    logic [0:0] rc_b, wc_b;
    logic [3:0] wa_b;

    pool_cu_gen #(.IFM_SIZE(5), .IFM_DEPTH(1), .KERNAL_SIZE(3), .STRIDE(1), .POOL_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset_b), .start_from_previous(start_b), .end_from_next(efn_b),
        .pool_mode_in(pmi_b), .end_to_previous(etp_b), .ifm_enable_read_current(rd_b),
        .ifm_address_read_current(ra_b), .ifm_channel_read_current(rc_b), .fifo_enable(fifo_b),
        .pool_enable(pe_b), .pool_mode(pm_b), .ifm_enable_write_next(wr_b),
        .ifm_address_write_next(wa_b), .ifm_channel_write_next(wc_b),
        .start_to_next(st_b), .ifm_sel_next(sel_b)
    );

    int exp_rd_a[$], exp_pe_a[$], exp_wr_a[$], exp_st_a[$], pe_cyc_a[$];
    int exp_rd_b[$], exp_pe_b[$], exp_wr_b[$], exp_st_b[$], pe_cyc_b[$];
    int deliv_a = 0, rd_seen_a = 0, wr_seen_a = 0, last_wr_a = 0, sel_exp_a = 0, exp_mode_a = 0;
    int deliv_b = 0, rd_seen_b = 0, wr_seen_b = 0, last_wr_b = 0, sel_exp_b = 0, exp_mode_b = 0;
    bit sel_pend_a = 0, gap_chk_a = 0, sel_pend_b = 0, gap_chk_b = 0;

    int pe_tab_a[4] = '{5, 7, 13, 15};
    int pe_tab_b[9] = '{12, 13, 14, 17, 18, 19, 22, 23, 24};

    always @(negedge clk) begin
        if (reset_a) begin
            deliv_a = 0;
            sel_pend_a = 0;
            pe_cyc_a.delete();
        end else begin
            if (sel_pend_a) begin
                chk("a_sel_post", int'(sel_a), sel_exp_a);
                sel_pend_a = 0;
            end
            if (rd_a) begin
                rd_seen_a++;
                if (exp_rd_a.size() == 0) chk("a_rd_unexpected", int'(ra_a), -1);
                else chk("a_rd_addr", int'(rc_a) * 16 + int'(ra_a), exp_rd_a.pop_front());
                chk("a_pool_mode", int'(pm_a), exp_mode_a);
            end
            if (pe_a) begin
                if (exp_pe_a.size() == 0) chk("a_pe_unexpected", deliv_a % 32, -1);
                else chk("a_pe_pixel", deliv_a % 32, exp_pe_a.pop_front());
                pe_cyc_a.push_back(cyc);
            end
            if (fifo_a) deliv_a++;
            if (wr_a) begin
                wr_seen_a++;
                if (exp_wr_a.size() == 0) chk("a_wr_unexpected", int'(wa_a), -1);
                else chk("a_wr_addr", int'(wc_a) * 4 + int'(wa_a), exp_wr_a.pop_front());
                if (pe_cyc_a.size() != 0) chk("a_wr_latency", cyc - pe_cyc_a.pop_front(), 3);
                last_wr_a = cyc;
            end
            if (st_a) begin
                if (exp_st_a.size() == 0) chk("a_start_unexpected", int'(sel_a), -1);
                else begin
                    sel_exp_a = exp_st_a.pop_front();
                    chk("a_sel_pre", int'(sel_a), sel_exp_a ^ 1);
                    sel_pend_a = 1;
                    if (gap_chk_a) chk("a_start_gap", cyc - last_wr_a, 1);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (reset_b) begin
            deliv_b = 0;
            sel_pend_b = 0;
            pe_cyc_b.delete();
        end else begin
            if (sel_pend_b) begin
                chk("b_sel_post", int'(sel_b), sel_exp_b);
                sel_pend_b = 0;
            end
            if (rd_b) begin
                rd_seen_b++;
                if (exp_rd_b.size() == 0) chk("b_rd_unexpected", int'(ra_b), -1);
                else chk("b_rd_addr", int'(rc_b) * 32 + int'(ra_b), exp_rd_b.pop_front());
                chk("b_pool_mode", int'(pm_b), exp_mode_b);
            end
            if (pe_b) begin
                if (exp_pe_b.size() == 0) chk("b_pe_unexpected", deliv_b % 25, -1);
                else chk("b_pe_pixel", deliv_b % 25, exp_pe_b.pop_front());
                pe_cyc_b.push_back(cyc);
            end
            if (fifo_b) deliv_b++;
            if (wr_b) begin
                wr_seen_b++;
                if (exp_wr_b.size() == 0) chk("b_wr_unexpected", int'(wa_b), -1);
                else chk("b_wr_addr", int'(wc_b) * 16 + int'(wa_b), exp_wr_b.pop_front());
                if (pe_cyc_b.size() != 0) chk("b_wr_latency", cyc - pe_cyc_b.pop_front(), 3);
                last_wr_b = cyc;
            end
            if (st_b) begin
                if (exp_st_b.size() == 0) chk("b_start_unexpected", int'(sel_b), -1);
                else begin
                    sel_exp_b = exp_st_b.pop_front();
                    chk("b_sel_pre", int'(sel_b), sel_exp_b ^ 1);
                    sel_pend_b = 1;
                    if (gap_chk_b) chk("b_start_gap", cyc - last_wr_b, 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start_a();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic pulse_start_b();
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
    endtask

    task automatic push_frame_a();
        for (int ch = 0; ch < 2; ch++) begin
            for (int p = 0; p < 16; p++) exp_rd_a.push_back(ch * 16 + p);
            for (int i = 0; i < 4; i++) begin
                exp_pe_a.push_back(ch * 16 + pe_tab_a[i]);
                exp_wr_a.push_back(ch * 4 + i);
            end
        end
    endtask

    task automatic push_frame_b();
        for (int p = 0; p < 25; p++) exp_rd_b.push_back(p);
        for (int i = 0; i < 9; i++) begin
            exp_pe_b.push_back(pe_tab_b[i]);
            exp_wr_b.push_back(i);
        end
    endtask

    task automatic wait_frame_a(input int budget);
        int n = 0;
        while ((exp_rd_a.size() != 0 || exp_wr_a.size() != 0 || !etp_a) && n < budget) begin
            tick();
            n++;
        end
        chk("a_frame_within_budget", int'(n < budget), 1);
    endtask

    task automatic wait_frame_b(input int budget);
        int n = 0;
        while ((exp_rd_b.size() != 0 || exp_wr_b.size() != 0 || !etp_b) && n < budget) begin
            tick();
            n++;
        end
        chk("b_frame_within_budget", int'(n < budget), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got time limit expected summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, w0;
        reset_a = 1'b1; reset_b = 1'b1;
        start_a = 1'b0; start_b = 1'b0;
        efn_a = 1'b1; efn_b = 1'b1;
        pmi_a = 1'b0; pmi_b = 1'b0;
        tick();
        tick();
        chk("a_rst_etp", int'(etp_a), 1);
        chk("a_rst_rd", int'(rd_a), 0);
        chk("a_rst_fifo", int'(fifo_a), 0);
        chk("a_rst_pe", int'(pe_a), 0);
        chk("a_rst_wr", int'(wr_a), 0);
        chk("a_rst_start", int'(st_a), 0);
        chk("a_rst_sel", int'(sel_a), 0);
        chk("a_rst_mode", int'(pm_a), 0);
        chk("b_rst_etp", int'(etp_b), 1);
        chk("b_rst_sel", int'(sel_b), 0);
        reset_a = 1'b0; reset_b = 1'b0;
        tick();

        // Frame with mode latch and an ignored start pulse mid-frame
        pmi_a = 1'b1; exp_mode_a = 1; gap_chk_a = 1;
        push_frame_a();
        exp_st_a.push_back(1);
        pulse_start_a();
        repeat (6) tick();
        pmi_a = 1'b0;
        pulse_start_a();
        wait_frame_a(200);
        repeat (4) tick();
        chk("a_f1_start_done", exp_st_a.size(), 0);
        chk("a_f1_pe_done", exp_pe_a.size(), 0);
        chk("a_mode_held", int'(pm_a), 1);
        chk("a_f1_reads", rd_seen_a, 32);

        // 3x3 stride-1 window on a 5x5 map
        exp_mode_b = 0; gap_chk_b = 1;
        push_frame_b();
        exp_st_b.push_back(1);
        pulse_start_b();
        wait_frame_b(200);
        repeat (4) tick();
        chk("b_start_done", exp_st_b.size(), 0);
        chk("b_pe_done", exp_pe_b.size(), 0);
        chk("b_reads", rd_seen_b, 25);

        // Back-to-back frames with the next layer busy
        efn_a = 1'b0; gap_chk_a = 0; exp_mode_a = 0;
        push_frame_a();
        exp_st_a.push_back(0);
        pulse_start_a();
        wait_frame_a(200);
        repeat (3) tick();
        chk("a_full_no_start", exp_st_a.size(), 1);
        r0 = rd_seen_a; w0 = wr_seen_a;
        push_frame_a();
        exp_st_a.push_back(1);
        pulse_start_a();
        repeat (12) tick();
        chk("a_stall_reads", rd_seen_a - r0, 4);
        chk("a_stall_writes", wr_seen_a - w0, 0);
        chk("a_hold_addr", int'(ra_a), 4);
        chk("a_hold_ch", int'(rc_a), 0);
        chk("a_hold_rd", int'(rd_a), 0);
        chk("a_hold_etp", int'(etp_a), 0);
        efn_a = 1'b1;
        tick();
        chk("a_resume_rd", int'(rd_a), 1);
        chk("a_resume_addr", int'(ra_a), 4);
        chk("a_resume_no_write", wr_seen_a - w0, 0);
        gap_chk_a = 1;
        wait_frame_a(300);
        repeat (4) tick();
        chk("a_b2b_start_done", exp_st_a.size(), 0);
        chk("a_b2b_sel", int'(sel_a), 1);

        // Reset in the middle of a frame
        pmi_a = 1'b1; exp_mode_a = 1;
        push_frame_a();
        pulse_start_a();
        repeat (10) tick();
        reset_a = 1'b1;
        exp_rd_a.delete(); exp_pe_a.delete(); exp_wr_a.delete(); exp_st_a.delete();
        #1;
        chk("a_mid_rst_etp", int'(etp_a), 1);
        chk("a_mid_rst_rd", int'(rd_a), 0);
        chk("a_mid_rst_sel", int'(sel_a), 0);
        chk("a_mid_rst_mode", int'(pm_a), 0);
        chk("a_mid_rst_addr", int'(ra_a), 0);
        tick();
        tick();
        reset_a = 1'b0;
        w0 = wr_seen_a;
        repeat (15) tick();
        chk("a_post_rst_writes", wr_seen_a - w0, 0);
        chk("a_post_rst_etp", int'(etp_a), 1);
        chk("a_post_rst_sel", int'(sel_a), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
